// File: rtl/octal_ser_pkg.sv
// Shared types and helpers for the octal digit serializer.
package octal_ser_pkg;

  localparam int unsigned DIG_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int unsigned ndig(input int unsigned data_w);
    return (data_w + 2) / 3;
  endfunction

endpackage

// File: rtl/octal_lz_count.sv
// Priority encoder: number of significant octal digits in a padded word (minimum 1).
module octal_lz_count
  import octal_ser_pkg::*;
#(
  parameter  int unsigned NDIG  = 4,
  localparam int unsigned PAD_W = DIG_W * NDIG,
  localparam int unsigned CNT_W = $clog2(NDIG + 1)
) (
  input  logic [PAD_W-1:0] word,
  output logic [CNT_W-1:0] nsig
);

  // Ascending scan so the highest nonzero digit wins.
  always_comb begin
    nsig = CNT_W'(1);
    for (int i = 0; i < int'(NDIG); i++) begin
      if (word[i*DIG_W +: DIG_W] != '0) nsig = CNT_W'(i + 1);
    end
  end

endmodule

// File: rtl/octal_digit_serializer.sv
// Emits a binary word as octal digits, MSD first, over a valid/ready stream.
module octal_digit_serializer
  import octal_ser_pkg::*;
#(
  parameter  int unsigned DATA_W      = 12,
  parameter  bit          SUPPRESS_LZ = 1'b1,
  localparam int unsigned NDIG        = ndig(DATA_W),
  localparam int unsigned POS_W       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              dig_valid,
  input  logic              dig_ready,
  output logic [DIG_W-1:0]  dig_out,
  output logic [POS_W-1:0]  dig_pos,
  output logic              dig_last
);

  localparam int unsigned PAD_W = DIG_W * NDIG;
  localparam int unsigned CNT_W = $clog2(NDIG + 1);

  state_t           state;
  logic [PAD_W-1:0] sreg;
  logic [PAD_W-1:0] padded;
  logic [PAD_W-1:0] aligned;
  logic [PAD_W-1:0] next_sreg;
  logic [CNT_W-1:0] nsig_lz;
  logic [CNT_W-1:0] nsig_sel;

  assign in_ready = (state == IDLE);

  octal_lz_count #(.NDIG(NDIG)) u_lz (
    .word (padded),
    .nsig (nsig_lz)
  );

  // Capture path: left-align so the top significant digit sits in the MSBs.
  always_comb begin
    padded    = PAD_W'(in_data);
    nsig_sel  = SUPPRESS_LZ ? nsig_lz : CNT_W'(NDIG);
    aligned   = padded << (DIG_W * (NDIG - 32'(nsig_sel)));
    next_sreg = sreg << DIG_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      dig_valid <= 1'b0;
      dig_out   <= '0;
      dig_pos   <= '0;
      dig_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EMIT;
            sreg      <= aligned;
            dig_valid <= 1'b1;
            dig_out   <= aligned[PAD_W-1 -: DIG_W];
            dig_pos   <= POS_W'(nsig_sel - CNT_W'(1));
            dig_last  <= (nsig_sel == CNT_W'(1));
          end
        end
        EMIT: begin
          if (dig_ready) begin
            if (dig_pos == '0) begin
              state     <= IDLE;
              dig_valid <= 1'b0;
            end else begin
              sreg     <= next_sreg;
              dig_out  <= next_sreg[PAD_W-1 -: DIG_W];
              dig_pos  <= dig_pos - POS_W'(1);
              dig_last <= (dig_pos == POS_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_octal_digit_serializer.sv
// Directed bench for octal_digit_serializer: 12-bit suppressing and 8-bit full-width configs.
module tb_octal_digit_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dig_ready;

  logic        in_valid1, in_ready1, dig_valid1, dig_last1;
  logic [11:0] in_data1;
  logic [2:0]  dig_out1;
  logic [1:0]  dig_pos1;

  logic        in_valid2, in_ready2, dig_valid2, dig_last2;
  logic [7:0]  in_data2;
  logic [2:0]  dig_out2;
  logic [1:0]  dig_pos2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  octal_digit_serializer #(.DATA_W(12), .SUPPRESS_LZ(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .dig_valid(dig_valid1), .dig_ready(dig_ready), .dig_out(dig_out1),
    .dig_pos(dig_pos1), .dig_last(dig_last1)
  );

  octal_digit_serializer #(.DATA_W(8), .SUPPRESS_LZ(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .dig_valid(dig_valid2), .dig_ready(dig_ready), .dig_out(dig_out2),
    .dig_pos(dig_pos2), .dig_last(dig_last2)
  );

  typedef struct {
    bit          cfg;   // 0: 12-bit suppressing instance, 1: 8-bit full-width instance
    logic [11:0] data;
    int          n;     // expected digit count
    logic [11:0] digs;  // expected digits, octal, right-aligned, MSD first
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] get_valid(input bit cfg);
    return cfg ? 32'(dig_valid2) : 32'(dig_valid1);
  endfunction
  function automatic logic [31:0] get_out(input bit cfg);
    return cfg ? 32'(dig_out2) : 32'(dig_out1);
  endfunction
  function automatic logic [31:0] get_pos(input bit cfg);
    return cfg ? 32'(dig_pos2) : 32'(dig_pos1);
  endfunction
  function automatic logic [31:0] get_last(input bit cfg);
    return cfg ? 32'(dig_last2) : 32'(dig_last1);
  endfunction
  function automatic logic [31:0] get_ready(input bit cfg);
    return cfg ? 32'(in_ready2) : 32'(in_ready1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word, then expects n digits on consecutive cycles with dig_ready high.
  task automatic run_word(input bit cfg, input logic [11:0] data, input int n,
                          input logic [11:0] digs, input string tag);
    dig_ready = 1'b1;
    check({tag, "_in_ready_pre"}, get_ready(cfg), 1);
    if (cfg) begin in_valid2 = 1'b1; in_data2 = data[7:0]; end
    else     begin in_valid1 = 1'b1; in_data1 = data; end
    tick();
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_valid%0d", tag, k), get_valid(cfg), 1);
      check($sformatf("%s_ready%0d", tag, k), get_ready(cfg), 0);
      check($sformatf("%s_dig%0d", tag, k), get_out(cfg), 32'(digs[3*(n-1-k) +: 3]));
      check($sformatf("%s_pos%0d", tag, k), get_pos(cfg), 32'(n - 1 - k));
      check($sformatf("%s_last%0d", tag, k), get_last(cfg), (k == n - 1) ? 1 : 0);
      tick();
    end
    check({tag, "_in_ready_post"}, get_ready(cfg), 1);
    check({tag, "_valid_post"}, get_valid(cfg), 0);
  endtask

  initial begin
    vecs[0] = '{cfg: 1'b0, data: 12'o1234, n: 4, digs: 12'o1234};
    vecs[1] = '{cfg: 1'b0, data: 12'o0017, n: 2, digs: 12'o0017};
    vecs[2] = '{cfg: 1'b0, data: 12'o0000, n: 1, digs: 12'o0000};
    vecs[3] = '{cfg: 1'b0, data: 12'o4000, n: 4, digs: 12'o4000};
    vecs[4] = '{cfg: 1'b1, data: 12'h0FF,  n: 3, digs: 12'o0377};
    vecs[5] = '{cfg: 1'b1, data: 12'h001,  n: 3, digs: 12'o0001};

    rst = 1'b1; dig_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0;
    in_valid2 = 1'b0; in_data2 = '0;
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rst_valid_c%0d", c), get_valid(c[0]), 0);
      check($sformatf("rst_out_c%0d", c), get_out(c[0]), 0);
      check($sformatf("rst_pos_c%0d", c), get_pos(c[0]), 0);
      check($sformatf("rst_last_c%0d", c), get_last(c[0]), 0);
      check($sformatf("rst_ready_c%0d", c), get_ready(c[0]), 1);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_word(vecs[i].cfg, vecs[i].data, vecs[i].n, vecs[i].digs, $sformatf("vec%0d", i));

    // Backpressure on the second digit of 7654, with in_valid pulses ignored during EMIT.
    dig_ready = 1'b1;
    in_valid1 = 1'b1; in_data1 = 12'o7654;
    tick();
    in_data1 = 12'o0003;
    check("bp_d0", get_out(0), 7);
    check("bp_p0", get_pos(0), 3);
    tick();
    dig_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp_hold_valid%0d", s), get_valid(0), 1);
      check($sformatf("bp_hold_dig%0d", s), get_out(0), 6);
      check($sformatf("bp_hold_pos%0d", s), get_pos(0), 2);
      check($sformatf("bp_hold_ready%0d", s), get_ready(0), 0);
      in_valid1 = s[0];
      tick();
    end
    in_valid1 = 1'b0;
    dig_ready = 1'b1;
    check("bp_d1", get_out(0), 6);
    tick();
    check("bp_d2", get_out(0), 5);
    check("bp_p2", get_pos(0), 1);
    tick();
    check("bp_d3", get_out(0), 4);
    check("bp_last3", get_last(0), 1);
    tick();
    check("bp_done_valid", get_valid(0), 0);
    check("bp_done_ready", get_ready(0), 1);

    // Reset mid-word: remaining digits of 1234 must vanish.
    in_valid1 = 1'b1; in_data1 = 12'o1234;
    tick();
    in_valid1 = 1'b0;
    check("mr_d0", get_out(0), 1);
    tick();
    check("mr_d1", get_out(0), 2);
    tick();
    check("mr_d2", get_out(0), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", get_valid(0), 0);
    check("mr_ready", get_ready(0), 1);
    tick();
    check("mr_valid_after", get_valid(0), 0);
    run_word(1'b0, 12'o0005, 1, 12'o0005, "mr_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/octal_digit_serializer.md
# octal_digit_serializer

Converts a binary word into a serial stream of 3-bit octal digits, most significant first, with optional leading-zero suppression. Sits directly upstream of the 3-to-8 one-hot decoder in the base_conversion design. Each emitted digit drives the decoder's 3-bit input, one digit per handshake. Uses valid/ready on both sides so display or lamp logic can pace the output.

## Interface
- DATA_W, 12, width of the binary input word, ≥ 3
- SUPPRESS_LZ, 1, 1 = skip leading zero digits (always emit at least one digit); 0 = always emit NDIG digits
- NDIG (localparam), ceil(DATA_W/3), maximum digit count
- POS_W (localparam), max(1, $clog2(NDIG)), width of dig_pos
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a word; high exactly when state is IDLE
- in_data  in  DATA_W  binary word to convert
- dig_valid  out  1  dig_out, dig_pos and dig_last are valid
- dig_ready  in  1  downstream accepts the current digit
- dig_out  out  3  current octal digit, fed to the decoder's 3-bit input
- dig_pos  out  POS_W  octal place of the current digit (weight 8^dig_pos)
- dig_last  out  1  current digit is the final digit of the word (dig_pos == 0)

## Operation
- States: IDLE, EMIT.
- IDLE:
  - in_ready = 1 and dig_valid = 0.
  - On in_valid & in_ready, zero-pad in_data on the MSB side to 3*NDIG bits.
  - Compute nsig, the index of the highest nonzero digit + 1, with a minimum of 1.
  - With SUPPRESS_LZ = 0, nsig = NDIG.
  - Left-align the padded word by (NDIG − nsig)*3 bits into the shift register and load pos = nsig − 1. Go to EMIT.
- EMIT:
  - dig_valid = 1.
  - dig_out = top 3 bits of the shift register.
  - dig_pos = pos.
  - dig_last = (pos == 0).
- On dig_valid & dig_ready:
  - If pos == 0, go to IDLE.
  - Otherwise shift left by 3, decrement pos, and stay in EMIT.
- Backpressure: while dig_valid & !dig_ready, dig_out, dig_pos and dig_last are held stable. No digit is dropped or duplicated.
- in_valid is ignored outside IDLE; in_ready is 0 there, so no handshake can occur.
- Input 0 produces exactly one digit: 0, pos 0, last 1 (with SUPPRESS_LZ = 1).
- Arithmetic: pure bit slicing. When DATA_W is not a multiple of 3, the top digit takes the leftover 1 or 2 bits, zero-extended.
- Reset:
  - Registered outputs are forced on the clock edge: state IDLE, dig_valid 0, dig_out 0, dig_pos 0, dig_last 0, shift register 0.
  - in_ready is 1 from the first cycle after reset.
  - A reset mid-word aborts that word; the remaining digits are discarded and never emitted.

## Timing
- All outputs except in_ready are registered; in_ready is decoded from state only.
- Input latency: first digit has dig_valid = 1 in the cycle after the input handshake.
- Throughput: with dig_ready held high, one digit per cycle.
- in_ready returns to 1 in the cycle after the last-digit handshake.
- A word therefore occupies nsig + 1 cycles per input.
- No combinational path from dig_ready or in_valid to any output.

## Structure
- Package octal_ser_pkg holds:
  - state enum (IDLE, EMIT);
  - function ndig(DATA_W) = (DATA_W + 2)/3;
  - constant DIG_W = 3.
- Sub-module octal_lz_count: combinational priority encoder. Takes the padded word and returns nsig (min 1). Instantiated once, used only in the IDLE capture path.
- Top module holds the FSM, shift register and pos counter.

## Test plan
- DATA_W = 12, SUPPRESS_LZ = 1, in_data = 12'o1234, dig_ready = 1:
  - digits 1, 2, 3, 4 on 4 consecutive cycles starting the cycle after acceptance;
  - dig_pos 3, 2, 1, 0; dig_last on digit 4;
  - in_ready = 1 the following cycle.
- in_data = 12'o0017 → digits 1, 7 with dig_pos 1, 0.
- in_data = 0 → single digit 0, dig_pos 0, dig_last 1.
- in_data = 12'o7654, dig_ready low for 3 cycles while digit 6 is presented:
  - dig_out holds 6 and dig_pos holds 2 throughout;
  - the stream completes as 7, 6, 5, 4;
  - in_valid pulses during EMIT are ignored.
- Reset asserted one cycle after digit 2 of 12'o1234 is accepted:
  - next cycle dig_valid = 0, in_ready = 1;
  - new word 12'o0005 then yields the single digit 5, last.
- DATA_W = 8, SUPPRESS_LZ = 0, in_data = 8'hFF → 3, 7, 7 with dig_pos 2, 1, 0.
- Same configuration, in_data = 8'h01 → 0, 0, 1.
